io_ring_pwr_seq: RTL

- Sequences power-up and power-down of the pad-ring supply segments, each fed by VDD/VDDIO supply pad cells.
- Drives per-segment pad isolation and output-driver enables in a safe order, with staggered, programmable settle delays to limit inrush.
- Sits in the always-on domain between the power-management controller and the IO ring.
- Latches a fault whenever a segment's supply drops while that segment is live.

---
 rtl/io_ring_pwr_pkg.sv | 23 ++
 rtl/io_ring_pwr_sync.sv | 22 ++
 rtl/io_ring_pwr_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/io_ring_pwr_pkg.sv
// Shared types and helpers for the IO-ring power sequencer.
package io_ring_pwr_pkg;

    localparam int DEF_NUM_SEG     = 4;
    localparam int DEF_SETTLE_W    = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int MAX_SEG         = 16;

    typedef enum logic [3:0] {
        OFF, WAIT_SUP, SETTLE, REL_ISO, REL_WAIT, DRV_EN,
        ON, DRV_DIS, DIS_WAIT, ISO_ON, FAULT
    } pwr_state_t;

    // Lowest set bit of mask at index >= from, or -1 if there is none.
    function automatic int next_set(input logic [MAX_SEG-1:0] mask, input int from);
        int idx;
        idx = -1;
        for (int i = MAX_SEG - 1; i >= 0; i--)
            if (i >= from && mask[i]) idx = i;
        return idx;
    endfunction

endpackage

// File: rtl/io_ring_pwr_sync.sv
// Multi-flop synchronizer for a vector of quasi-static supply-good levels.
module io_ring_pwr_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] pipe;

    // Reset to "not ok" so nothing is trusted until the chain has filled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[STAGES-2:0], d};
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/io_ring_pwr_seq.sv
// Pad-ring power sequencer: staggered isolation release, driver enable,
// ordered power-down and latched supply-loss fault.
module io_ring_pwr_seq
    import io_ring_pwr_pkg::*;
#(
    parameter int NUM_SEG     = DEF_NUM_SEG,
    parameter int SETTLE_W    = DEF_SETTLE_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    localparam int IDX_W      = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                vdd_ok_i,
    input  logic [NUM_SEG-1:0]  vddio_ok_i,
    input  logic [NUM_SEG-1:0]  seg_mask_i,
    input  logic [SETTLE_W-1:0] settle_i,
    input  logic                pwr_up_req_i,
    input  logic                pwr_dn_req_i,
    output logic [NUM_SEG-1:0]  seg_iso_o,
    output logic [NUM_SEG-1:0]  seg_drv_en_o,
    output logic                busy_o,
    output logic                ready_o,
    output logic                fault_o,
    output logic [IDX_W-1:0]    fault_seg_o
);

    localparam logic [SETTLE_W-1:0] ONE = SETTLE_W'(1);

    pwr_state_t          state, nxt;
    logic [NUM_SEG:0]    sync_q;
    logic                vdd_s;
    logic [NUM_SEG-1:0]  vddio_s, act_mask, fail_vec, iso_q, drv_q;
    logic [SETTLE_W-1:0] cnt, settle_eff;
    logic [IDX_W-1:0]    ptr, fault_seg_q;
    logic                ready_q, fault_q, sup_ok, live, loss, expired, load;
    int                  from_idx, nidx, fidx;

    io_ring_pwr_sync #(.W(NUM_SEG + 1), .STAGES(SYNC_STAGES)) u_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   ({vdd_ok_i, vddio_ok_i}),
        .q   (sync_q)
    );
    assign vdd_s   = sync_q[NUM_SEG];
    assign vddio_s = sync_q[NUM_SEG-1:0];

    always_comb begin
        fail_vec   = act_mask & ~vddio_s;
        sup_ok     = vdd_s && (fail_vec == '0);
        live       = state inside {SETTLE, REL_ISO, REL_WAIT, DRV_EN, ON};
        loss       = live && !sup_ok;
        expired    = (cnt <= ONE);
        settle_eff = (settle_i == '0) ? ONE : settle_i;
        from_idx   = (state == SETTLE) ? 0 : int'(ptr) + 1;
        nidx       = next_set(MAX_SEG'(act_mask), from_idx);
        fidx       = next_set(MAX_SEG'(fail_vec), 0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= OFF;
        else       state <= nxt;
    end

    // Supply loss outranks everything; a down request outranks an up request.
    always_comb begin
        nxt = state;
        unique case (state)
            OFF:      if (!pwr_dn_req_i && pwr_up_req_i && seg_mask_i != '0) nxt = WAIT_SUP;
            WAIT_SUP: if (pwr_dn_req_i) nxt = ISO_ON;
                      else if (sup_ok) nxt = SETTLE;
            SETTLE:   if (loss) nxt = FAULT;
                      else if (pwr_dn_req_i) nxt = ISO_ON;
                      else if (expired) nxt = REL_ISO;
            REL_ISO:  if (loss) nxt = FAULT;
                      else if (pwr_dn_req_i) nxt = DRV_DIS;
                      else nxt = REL_WAIT;
            REL_WAIT: if (loss) nxt = FAULT;
                      else if (pwr_dn_req_i) nxt = DRV_DIS;
                      else if (expired) nxt = (nidx < 0) ? DRV_EN : REL_ISO;
            DRV_EN:   if (loss) nxt = FAULT;
                      else if (pwr_dn_req_i) nxt = DRV_DIS;
                      else nxt = ON;
            ON:       if (loss) nxt = FAULT;
                      else if (pwr_dn_req_i) nxt = DRV_DIS;
            DRV_DIS:  nxt = expired ? ISO_ON : DIS_WAIT;
            DIS_WAIT: if (expired) nxt = ISO_ON;
            ISO_ON:   nxt = OFF;
            FAULT:    if (pwr_dn_req_i) nxt = OFF;
            default:  nxt = OFF;
        endcase
    end

    // The power-down wait starts on entry to DRV_DIS, so DRV_DIS counts as its first cycle.
    assign load = (state == WAIT_SUP && nxt == SETTLE) ||
                  (state == REL_ISO && nxt == REL_WAIT) || (nxt == DRV_DIS);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt         <= '0;
            ptr         <= '0;
            act_mask    <= '0;
            iso_q       <= '1;
            drv_q       <= '0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            fault_seg_q <= '0;
        end else begin
            if (state == OFF && nxt == WAIT_SUP) act_mask <= seg_mask_i;
            else if (nxt == OFF)                 act_mask <= '0;

            if (load)            cnt <= settle_eff;
            else if (!expired)   cnt <= cnt - ONE;

            if (nxt == REL_ISO && (state == SETTLE || state == REL_WAIT))
                ptr <= IDX_W'(nidx);

            if (nxt == ISO_ON || nxt == FAULT)           iso_q      <= '1;
            else if (state == REL_ISO && nxt == REL_WAIT) iso_q[ptr] <= 1'b0;

            drv_q   <= (nxt == ON) ? act_mask : '0;
            ready_q <= (state == ON) && (nxt == ON);

            if (state != FAULT && nxt == FAULT) begin
                fault_q     <= 1'b1;
                fault_seg_q <= (fidx < 0) ? '0 : IDX_W'(fidx);
            end else if (state == FAULT && nxt == OFF) begin
                fault_q     <= 1'b0;
            end
        end
    end

    // Safe values are forced combinationally in the cycle the loss is seen.
    always_comb begin
        seg_iso_o    = loss ? '1 : iso_q;
        seg_drv_en_o = loss ? '0 : drv_q;
        busy_o       = !(state inside {OFF, ON, FAULT});
        ready_o      = ready_q;
        fault_o      = fault_q;
        fault_seg_o  = fault_seg_q;
    end

endmodule
